// File: rtl/irq_ctrl.sv
// Eight-source interrupt controller: enable/pending/mode registers, lowest-index
// arbitration and an IDLE/ACTIVE/GAP handshake. Define IRQ_SYNC_EN to add a 2-flop input synchronizer.
module irq_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] address,
  input  logic        WE,
  input  logic [31:0] dataIn,
  output logic [31:0] dataOut,
  input  logic [7:0]  irq_src,
  output logic        IRQ,
  output logic [2:0]  irq_id
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  enable_q, enable_d;
  logic [7:0]  pending_q, pending_d;
  logic [7:0]  mode_q, mode_d;
  logic [7:0]  srcDly_q;
  logic [2:0]  irqId_q, irqId_d;
  logic [1:0]  armCnt_q;
  logic [7:0]  srcSample;

`ifdef IRQ_SYNC_EN
  // Edge detection stays disarmed until the synchronizer and delayed copy hold real samples.
  localparam logic [1:0] ArmEdges = 2'd3;

  logic [7:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_src;
      sync2_q <= sync1_q;
    end
  end

  assign srcSample = sync2_q;
`else
  localparam logic [1:0] ArmEdges = 2'd1;

  assign srcSample = irq_src;
`endif

  logic [1:0] regSel;
  logic       wrEnable, wrPending, wrMode, wrClaim;
  logic       armed;
  logic       claimHit;
  logic [7:0] rise;
  logic [7:0] w1cMask;
  logic [7:0] doneMask;
  logic [7:0] pendReq;
  logic [2:0] winner;
  logic       unusedBits;

  assign unusedBits = ^{address[31:4], dataIn[31:8]};

  assign regSel    = address[3:2];
  assign wrEnable  = WE && (regSel == 2'd0);
  assign wrPending = WE && (regSel == 2'd1);
  assign wrMode    = WE && (regSel == 2'd2);
  assign wrClaim   = WE && (regSel == 2'd3);

  assign armed    = (armCnt_q == ArmEdges);
  assign rise     = srcSample & ~srcDly_q & {8{armed}};
  assign claimHit = (state_q == ACTIVE) && wrClaim && (dataIn[2:0] == irqId_q);
  assign w1cMask  = wrPending ? dataIn[7:0] : 8'h00;
  assign doneMask = claimHit ? (8'h01 << irqId_q) : 8'h00;

  assign enable_d = wrEnable ? dataIn[7:0] : enable_q;
  assign mode_d   = wrMode ? dataIn[7:0] : mode_q;

  // Edge-pending survives only while the bit was already an edge source, so a
  // stale level value is never carried across a level-to-edge mode switch.
  assign pending_d = (mode_d & (rise | (pending_q & mode_q & ~(w1cMask | doneMask))))
                   | (~mode_d & srcSample);

  assign pendReq = pending_q & enable_q;

  always_comb begin
    winner = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pendReq[i]) begin
        winner = i[2:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    irqId_d = irqId_q;
    case (state_q)
      IDLE: begin
        if (|pendReq) begin
          irqId_d = winner;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (claimHit || !enable_q[irqId_q]) begin
          state_d = GAP;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      enable_q  <= '0;
      pending_q <= '0;
      mode_q    <= '0;
      srcDly_q  <= '0;
      irqId_q   <= '0;
      armCnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      enable_q  <= enable_d;
      pending_q <= pending_d;
      mode_q    <= mode_d;
      srcDly_q  <= srcSample;
      irqId_q   <= irqId_d;
      if (!armed) begin
        armCnt_q <= armCnt_q + 2'd1;
      end
    end
  end

  assign IRQ    = (state_q == ACTIVE);
  assign irq_id = irqId_q;

  always_comb begin
    dataOut = 32'h0;
    case (regSel)
      2'd0:    dataOut = {24'h0, enable_q};
      2'd1:    dataOut = {24'h0, pending_q};
      2'd2:    dataOut = {24'h0, mode_q};
      default: dataOut = {27'h0, IRQ, 1'b0, irqId_q};
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_irq_ctrl;

`ifdef IRQ_SYNC_EN
  localparam int LAT  = 3;
  localparam int ARM  = 3;
  localparam int SDLY = 2;
  localparam bit SYNC = 1'b1;
`else
  localparam int LAT  = 1;
  localparam int ARM  = 1;
  localparam int SDLY = 0;
  localparam bit SYNC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:2] address;
  logic        WE;
  logic [31:0] dataIn;
  logic [31:0] dataOut;
  logic [7:0]  irq_src;
  logic        IRQ;
  logic [2:0]  irq_id;

  int   errors = 0;
  int   checks = 0;
  bit   cmpOn = 1'b0;
  logic [7:0] srcNow = 8'h00;

  always #5 clk = ~clk;

  irq_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .address (address),
    .WE      (WE),
    .dataIn  (dataIn),
    .dataOut (dataOut),
    .irq_src (irq_src),
    .IRQ     (IRQ),
    .irq_id  (irq_id)
  );

  // Reference model: phase 0 = waiting, 1 = request raised, 2 = one-cycle pause.
  logic [7:0] mEn, mMode, mPend, mPrev, ms1, ms2;
  int         mPhase;
  logic [2:0] mId;
  int         mEdges;
  logic [7:0] samp, nEn, nMode, nPend;
  int         nPhase;
  logic [2:0] nId;
  logic       compl, found, rose, kill;

  always begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      mEn = 0; mMode = 0; mPend = 0; mPrev = 0; ms1 = 0; ms2 = 0;
      mPhase = 0; mId = 0; mEdges = 0;
    end else begin
      samp   = SYNC ? ms2 : irq_src;
      nEn    = (WE && address[3:2] == 2'd0) ? dataIn[7:0] : mEn;
      nMode  = (WE && address[3:2] == 2'd2) ? dataIn[7:0] : mMode;
      nPhase = mPhase;
      nId    = mId;
      compl  = 1'b0;
      if (mPhase == 0) begin
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
          if (!found && mPend[i] && mEn[i]) begin
            nId = 3'(i);
            found = 1'b1;
          end
        end
        if (found) nPhase = 1;
      end else if (mPhase == 1) begin
        if (WE && address[3:2] == 2'd3 && dataIn[2:0] == mId) begin
          compl = 1'b1;
          nPhase = 2;
        end else if (!mEn[mId]) begin
          nPhase = 2;
        end
      end else begin
        nPhase = 0;
      end
      for (int i = 0; i < 8; i++) begin
        if (nMode[i]) begin
          rose = samp[i] && !mPrev[i] && (mEdges >= ARM);
          kill = (WE && address[3:2] == 2'd1 && dataIn[i]) || (compl && int'(mId) == i);
          nPend[i] = rose || (mPend[i] && mMode[i] && !kill);
        end else begin
          nPend[i] = samp[i];
        end
      end
      mEn = nEn; mMode = nMode; mPend = nPend;
      mPhase = nPhase; mId = nId;
      ms2 = ms1; ms1 = irq_src; mPrev = samp;
      mEdges++;
    end
  end

  function automatic logic [31:0] expData();
    case (address[3:2])
      2'd0:    return {24'h0, mEn};
      2'd1:    return {24'h0, mPend};
      2'd2:    return {24'h0, mMode};
      default: return {27'h0, (mPhase == 1), 1'b0, mId};
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkIrq(input string name, input logic exp);
    checkOutput(name, {31'h0, IRQ}, {31'h0, exp});
  endtask

  task automatic checkId(input string name, input logic [2:0] exp);
    checkOutput(name, {29'h0, irq_id}, {29'h0, exp});
  endtask

  always @(negedge clk) begin
    if (cmpOn) begin
      checkOutput("modelIRQ", {31'h0, IRQ}, {31'h0, (mPhase == 1)});
      checkOutput("modelId", {29'h0, irq_id}, {29'h0, mId});
      checkOutput("modelData", dataOut, expData());
    end
  end

  task automatic applyStimulus(input logic we, input logic [1:0] a, input logic [31:0] d,
                               input logic [7:0] src);
    WE = we;
    address = {28'h0, a};
    dataIn = d;
    irq_src = src;
    srcNow = src;
    @(posedge clk);
    #1;
    WE = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 2'd3, 32'h0, srcNow);
  endtask

  task automatic waitIrq(input int maxC);
    int n;
    n = 0;
    while (IRQ !== 1'b1 && n < maxC) begin
      applyStimulus(1'b0, 2'd3, 32'h0, srcNow);
      n++;
    end
    checkIrq("waitIrqBound", 1'b1);
  endtask

  task automatic doReset();
    #2;
    reset = 1'b0;
    WE = 1'b0;
    irq_src = 8'h00;
    srcNow = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  logic        rWe;
  logic [1:0]  rA;
  logic [31:0] rD;
  logic [7:0]  rFlip;

  initial begin
    reset = 1'b0;
    WE = 1'b0;
    address = '0;
    dataIn = '0;
    irq_src = '0;
    repeat (2) @(posedge clk);
    #1;
    checkIrq("resetIrq", 1'b0);
    for (int a = 0; a < 4; a++) begin
      address = {28'h0, 2'(a)};
      #1;
      checkOutput("resetRegs", dataOut, 32'h0);
    end
    cmpOn = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Single edge pulse on source 0, claimed.
    idle(3);
    applyStimulus(1'b1, 2'd2, 32'h1, 8'h00);
    applyStimulus(1'b1, 2'd0, 32'h1, 8'h00);
    applyStimulus(1'b0, 2'd1, 32'h0, 8'h01);
    checkIrq("r33NoIrqAtSample", 1'b0);
    checkOutput("r33PendAtSample", dataOut, (LAT == 1) ? 32'h1 : 32'h0);
    for (int c = 1; c <= LAT; c++) begin
      applyStimulus(1'b0, 2'd3, 32'h0, 8'h00);
      checkIrq("r33Latency", (c == LAT));
    end
    checkId("r33Id", 3'd0);
    checkOutput("r33ClaimRead", dataOut, 32'h10);
    applyStimulus(1'b1, 2'd3, 32'h0, 8'h00);
    checkIrq("r33Gap", 1'b0);
    applyStimulus(1'b0, 2'd1, 32'h0, 8'h00);
    checkOutput("r33PendCleared", dataOut, 32'h0);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, 2'd3, 32'h0, 8'h00);
      checkIrq("r33StaysLow", 1'b0);
    end

    // Level source 1 held high re-asserts after the pause.
    doReset();
    idle(3);
    applyStimulus(1'b1, 2'd0, 32'h2, 8'h02);
    waitIrq(6);
    checkId("r34Id", 3'd1);
    applyStimulus(1'b1, 2'd3, 32'h1, 8'h02);
    checkIrq("r34Gap", 1'b0);
    waitIrq(4);
    checkId("r34Reassert", 3'd1);
    applyStimulus(1'b0, 2'd3, 32'h0, 8'h00);
    idle(3);
    checkIrq("r34StillActive", 1'b1);
    applyStimulus(1'b1, 2'd3, 32'h1, 8'h00);
    checkIrq("r34Claimed", 1'b0);
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0, 2'd3, 32'h0, 8'h00);
      checkIrq("r34NoMore", 1'b0);
    end

    // Simultaneous edges on bits 5 and 2: lowest index first.
    doReset();
    idle(3);
    applyStimulus(1'b1, 2'd2, 32'hFF, 8'h00);
    applyStimulus(1'b1, 2'd0, 32'hFF, 8'h00);
    applyStimulus(1'b0, 2'd3, 32'h0, 8'h24);
    waitIrq(6);
    checkId("r35First", 3'd2);
    applyStimulus(1'b1, 2'd3, 32'h2, 8'h24);
    checkIrq("r35Gap", 1'b0);
    waitIrq(4);
    checkId("r35Second", 3'd5);
    applyStimulus(1'b1, 2'd3, 32'h5, 8'h00);
    checkIrq("r35Done", 1'b0);
    idle(3);
    checkIrq("r35Quiet", 1'b0);

    // Mismatched claim ignored; set beats a concurrent W1C.
    doReset();
    idle(3);
    applyStimulus(1'b1, 2'd2, 32'hFF, 8'h00);
    applyStimulus(1'b1, 2'd0, 32'hFF, 8'h00);
    applyStimulus(1'b0, 2'd3, 32'h0, 8'h08);
    applyStimulus(1'b0, 2'd3, 32'h0, 8'h00);
    waitIrq(6);
    checkId("r36Id", 3'd3);
    applyStimulus(1'b1, 2'd3, 32'h4, 8'h00);
    checkOutput("r36BadClaim", dataOut, 32'h13);
    for (int c = 0; c < SDLY; c++) applyStimulus(1'b0, 2'd1, 32'h0, 8'h08);
    applyStimulus(1'b1, 2'd1, 32'h08, 8'h08);
    checkOutput("r36SetWins", dataOut, 32'h08);
    checkIrq("r36StillActive", 1'b1);
    applyStimulus(1'b1, 2'd3, 32'h3, 8'h08);
    checkIrq("r36Claimed", 1'b0);

    // Asynchronous reset mid-request, then a source held high through release.
    doReset();
    idle(3);
    applyStimulus(1'b1, 2'd2, 32'h1, 8'h00);
    applyStimulus(1'b1, 2'd0, 32'h1, 8'h00);
    applyStimulus(1'b0, 2'd3, 32'h0, 8'h01);
    applyStimulus(1'b0, 2'd3, 32'h0, 8'h00);
    waitIrq(6);
    #2;
    reset = 1'b0;
    #1;
    checkIrq("r37AsyncDrop", 1'b0);
    for (int a = 0; a < 4; a++) begin
      address = {28'h0, 2'(a)};
      #1;
      checkOutput("r37RegsZero", dataOut, 32'h0);
    end
    irq_src = 8'h01;
    srcNow = 8'h01;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(1'b1, 2'd2, 32'h1, 8'h01);
    applyStimulus(1'b1, 2'd0, 32'h1, 8'h01);
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b0, 2'd1, 32'h0, 8'h01);
      checkOutput("r37NoPend", dataOut, 32'h0);
      checkIrq("r37NoIrq", 1'b0);
    end

    // Randomized traffic checked by the model every cycle.
    doReset();
    for (int c = 0; c < 3000; c++) begin
      rWe = ($urandom_range(0, 3) == 0);
      rA = 2'($urandom_range(0, 3));
      rD = $urandom();
      if (rA == 2'd3 && $urandom_range(0, 1) == 1) rD[2:0] = mId;
      rFlip = 8'($urandom() & $urandom() & $urandom());
      applyStimulus(rWe, rA, rD, srcNow ^ rFlip);
      if ($urandom_range(0, 399) == 0) doReset();
    end

    cmpOn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
